// File: rtl/lsf_mul_round_sat_pipe.sv
// Pipelined signed multiply with round-half-up right shift and OUT_WIDTH range limiting.
// Define LSF_MUL_ROUND_SAT_PIPE_SAT_EN to clamp out-of-range results; otherwise p wraps.
module lsf_mul_round_sat_pipe #(
    parameter int A_WIDTH   = 15,
    parameter int B_WIDTH   = 22,
    parameter int OUT_WIDTH = 35,
    parameter int SHIFT     = 0,
    parameter int NUM_STAGE = 2,
    parameter int TAG_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    input  logic        [TAG_WIDTH-1:0] in_tag,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] p,
    output logic        [TAG_WIDTH-1:0] out_tag,
    output logic                        ovf
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int RW = PW + 1;
    localparam int MW = (RW > OUT_WIDTH) ? RW : OUT_WIDTH;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [RW-1:0] RND_K = (SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RS) : '0;
    localparam logic signed [MW-1:0] P_MAX = {{(MW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [MW-1:0] P_MIN = ~P_MAX;

    // One guard bit above the product keeps the rounding add from overflowing.
    function automatic logic signed [MW-1:0] round_shift(input logic signed [PW-1:0] x);
        logic signed [RW-1:0] t;
        t = RW'(x);
        t = t + $signed(RND_K);
        t = t >>> SHIFT;
        return MW'(t);
    endfunction

    function automatic logic range_ovf(input logic signed [MW-1:0] r);
        return (r > P_MAX) || (r < P_MIN);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] range_limit(input logic signed [MW-1:0] r);
`ifdef LSF_MUL_ROUND_SAT_PIPE_SAT_EN
        if (r > P_MAX) return P_MAX[OUT_WIDTH-1:0];
        if (r < P_MIN) return P_MIN[OUT_WIDTH-1:0];
`endif
        return r[OUT_WIDTH-1:0];
    endfunction

    logic signed [PW-1:0]        a_x, b_x, prod_c;
    logic signed [MW-1:0]        r_c;
    logic        [NUM_STAGE-1:1] vld_p;
    logic signed [PW-1:0]        prod_p [1:NUM_STAGE-1];
    logic        [TAG_WIDTH-1:0] tag_p  [1:NUM_STAGE-1];

    assign a_x    = PW'(a);
    assign b_x    = PW'(b);
    assign prod_c = a_x * b_x;
    assign r_c    = round_shift(prod_p[NUM_STAGE-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p     <= '0;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_p[i] <= '0;
                tag_p[i]  <= '0;
            end
            out_valid <= 1'b0;
            p         <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            // Stage 1: full-width product
            vld_p[1]  <= in_valid;
            prod_p[1] <= prod_c;
            tag_p[1]  <= in_tag;
            // Stages 2..NUM_STAGE-1: retiming
            for (int i = 2; i < NUM_STAGE; i++) begin
                vld_p[i]  <= vld_p[i-1];
                prod_p[i] <= prod_p[i-1];
                tag_p[i]  <= tag_p[i-1];
            end
            // Final stage: round, range-limit, flag
            out_valid <= vld_p[NUM_STAGE-1];
            p         <= range_limit(r_c);
            out_tag   <= tag_p[NUM_STAGE-1];
            ovf       <= vld_p[NUM_STAGE-1] & range_ovf(r_c);
        end
    end

endmodule

// File: doc/lsf_mul_round_sat_pipe.md
LSF_MUL_ROUND_SAT_PIPE -- requirements
Module: lsf_mul_round_sat_pipe

Interface
REQ-001 Parameter A_WIDTH, default 15: signed width of operand a.
REQ-002 Parameter B_WIDTH, default 22: signed width of operand b.
REQ-003 Parameter OUT_WIDTH, default 35: signed width of result p.
REQ-004 Parameter SHIFT, default 0, range 0..A_WIDTH+B_WIDTH-1: arithmetic right shift applied to the full product before output.
REQ-005 Parameter NUM_STAGE, default 2, range 2..6: latency in enabled cycles.
REQ-006 Parameter TAG_WIDTH, default 8: width of the sideband tag carried alongside the data.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 ce  input  1  pipeline enable; when 0, all stages hold.
REQ-010 in_valid  input  1  a, b and in_tag are valid this cycle.
REQ-011 a  input  A_WIDTH  signed operand.
REQ-012 b  input  B_WIDTH  signed operand.
REQ-013 in_tag  input  TAG_WIDTH  opaque sideband tag, e.g. r-bin index.
REQ-014 out_valid  output  1  p, out_tag and ovf are valid.
REQ-015 p  output  OUT_WIDTH  signed, rounded and range-limited product.
REQ-016 out_tag  output  TAG_WIDTH  in_tag delayed to match p.
REQ-017 ovf  output  1  the rounded product was outside the OUT_WIDTH signed range.

Function
REQ-018 An input sampled on an edge with ce=1 and in_valid=1 appears on p/out_tag/ovf with out_valid=1 after exactly NUM_STAGE edges with ce=1.
REQ-019 Edges with ce=0 do not advance the pipeline; every register, including the valid bits, holds its value.
REQ-020 Data and tag registers load only when ce=1; a bubble (in_valid=0) propagates as valid=0 and data content is don't-care.
REQ-021 Stage 1 registers the full A_WIDTH+B_WIDTH signed product; stages 2..NUM_STAGE-1 retime it; stage NUM_STAGE registers the round/limit result.
REQ-022 Rounding: for SHIFT>0, r = (P + 2^(SHIFT-1)) >>> SHIFT, evaluated at A_WIDTH+B_WIDTH+1 bits with no intermediate overflow (ties round toward +inf); for SHIFT=0, r = P.
REQ-023 Range limiting of r to OUT_WIDTH is defined by REQ-031/REQ-032; if OUT_WIDTH >= the width of r, p is r sign-extended and ovf is always 0.
REQ-024 ovf is registered in the same stage as p and is qualified by out_valid.
REQ-025 No backpressure: the block accepts one input per enabled cycle; the consumer samples outputs when out_valid=1.

Reset
REQ-026 While reset=1, out_valid, p, out_tag, ovf and all internal valid, data and tag registers are 0, regardless of clk or ce.
REQ-027 A reset asserted mid-operation discards all in-flight data; nothing emerges afterwards from inputs accepted before reset.
REQ-028 The first input accepted after reset deasserts produces the first out_valid=1, NUM_STAGE enabled edges later.

Configuration
REQ-029 The range-limiting feature is controlled by macro LSF_MUL_ROUND_SAT_PIPE_SAT_EN.
REQ-030 The macro is tested as a plain define, independently of all parameters.
REQ-031 With the macro defined: r > 2^(OUT_WIDTH-1)-1 gives p = 2^(OUT_WIDTH-1)-1 and ovf=1; r < -2^(OUT_WIDTH-1) gives p = -2^(OUT_WIDTH-1) and ovf=1; otherwise p = r and ovf=0.
REQ-032 With the macro undefined: p = r[OUT_WIDTH-1:0] (wrap-around); ovf still reports out-of-range, but p is not clamped.

Verification
Unless stated, scenarios use A=15, B=22, OUT=16, SHIFT=8, NUM_STAGE=3, TAG=8.
REQ-033 Rounding:
- a=300, b=-1000, tag=0x5A with ce=1 -> after 3 edges p=-1172, out_tag=0x5A, ovf=0, out_valid=1 for exactly one cycle.
- Tie cases: a=128, b=1 -> p=1; a=-128, b=1 -> p=0.
REQ-034 Range limiting, SAT_EN defined:
- a=16383, b=2097151 -> p=32767, ovf=1.
- a=-16384, b=2097151 -> p=-32768, ovf=1.
- SAT_EN undefined, same inputs -> p equals the low 16 bits of r, ovf=1.
REQ-035 Streaming with stalls:
- Back-to-back inputs tags 1..10 with ce toggling 1,0,1,1,0 -> outputs in order 1..10.
- Each output arrives after exactly 3 enabled edges; outputs hold during ce=0.
REQ-036 Reset mid-flight:
- Assert reset with 2 items in flight -> out_valid=0, p=0 immediately.
- After release, no stale outputs appear; the next input emerges after 3 edges.
REQ-037 Parameter sweep: NUM_STAGE=2 and 6, SHIFT=0, OUT_WIDTH=37, 10k random a/b -> p equals the exact product, latency matches NUM_STAGE, ovf is never 1.
